// File: rtl/tomasulo_pkg.sv
// Shared definitions for the Tomasulo core: tag layout, unit IDs, CDB field
// positions, divide op encodings and the divide core's state type.
package tomasulo_pkg;

    localparam int TAG_W     = 8;
    localparam int UNIT_ID_W = 5;
    localparam int RS_IDX_W  = TAG_W - UNIT_ID_W;

    localparam logic [UNIT_ID_W-1:0] UNIT_ALU = 5'b00001;
    localparam logic [UNIT_ID_W-1:0] UNIT_MUL = 5'b00010;
    localparam logic [UNIT_ID_W-1:0] UNIT_DIV = 5'b00100;
    localparam logic [UNIT_ID_W-1:0] UNIT_LS  = 5'b01000;

    // Divide op encodings; bit 0 selects unsigned, bit 1 selects remainder.
    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;
    localparam int OP_UNSIGNED_BIT = 0;
    localparam int OP_REM_BIT      = 1;

    // CDB layout is {valid, tag, value}; value occupies the low data_w bits.
    function automatic int cdb_tag_lsb(input int data_w);
        return data_w;
    endfunction

    function automatic int cdb_valid_bit(input int data_w);
        return data_w + TAG_W;
    endfunction

    typedef enum logic [2:0] {
        CS_IDLE,
        CS_LOAD,
        CS_ITER,
        CS_FIX,
        CS_DONE
    } core_state_e;

endpackage

// File: rtl/div_iter_core.sv
// Iterative radix-2 restoring divider shared by all divide reservation stations.
// Accepts one operation on start, produces one quotient bit per cycle, and
// holds the finished result until the bus acknowledges it.
module div_iter_core
    import tomasulo_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] dividend,
    input  logic [DATA_W-1:0] divisor,
    input  logic [TAG_W-1:0]  tag_in,
    input  logic              ack,
    output logic              busy,
    output logic              done,
    output logic [TAG_W-1:0]  tag,
    output logic [DATA_W-1:0] result
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [DATA_W-1:0] MIN_VAL = {1'b1, {(DATA_W-1){1'b0}}};

    core_state_e state, state_next;

    logic [1:0]        op_r;
    logic [DATA_W-1:0] a_r, b_r, quo, rem;
    logic [TAG_W-1:0]  tag_r;
    logic [CNT_W-1:0]  cnt;
    logic              neg_q, neg_r, skip;

    logic              is_signed, a_neg, b_neg, div_zero, overflow;
    logic [DATA_W-1:0] a_abs, b_abs;
    logic [DATA_W:0]   shifted, diff;

    // Operand sign/magnitude decode and the trial subtraction for one step.
    always_comb begin
        is_signed = ~op_r[OP_UNSIGNED_BIT];
        a_neg     = is_signed & a_r[DATA_W-1];
        b_neg     = is_signed & b_r[DATA_W-1];
        a_abs     = a_neg ? -a_r : a_r;
        b_abs     = b_neg ? -b_r : b_r;
        div_zero  = (b_r == '0);
        overflow  = is_signed & (a_r == MIN_VAL) & (b_r == '1);
        shifted   = {rem, quo[DATA_W-1]};
        diff      = shifted - {1'b0, b_r};
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) state <= CS_IDLE;
        else      state <= state_next;
    end

    // Next-state logic; special cases still pass through FIX (with fixing
    // suppressed) so their result appears two cycles after dispatch.
    always_comb begin
        state_next = state;
        case (state)
            CS_IDLE: if (start) state_next = CS_LOAD;
            CS_LOAD: state_next = (div_zero || overflow) ? CS_FIX : CS_ITER;
            CS_ITER: if (cnt == '0) state_next = CS_FIX;
            CS_FIX:  state_next = CS_DONE;
            CS_DONE: if (ack) state_next = CS_IDLE;
            default: state_next = CS_IDLE;
        endcase
    end

    // Datapath: operand latch, magnitude load, shift-subtract and sign fix.
    always_ff @(posedge clk) begin
        if (!rst) begin
            op_r  <= '0;
            a_r   <= '0;
            b_r   <= '0;
            quo   <= '0;
            rem   <= '0;
            tag_r <= '0;
            cnt   <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            skip  <= 1'b0;
        end else begin
            case (state)
                CS_IDLE: begin
                    if (start) begin
                        op_r  <= op;
                        a_r   <= dividend;
                        b_r   <= divisor;
                        tag_r <= tag_in;
                    end
                end
                CS_LOAD: begin
                    neg_q <= a_neg ^ b_neg;
                    neg_r <= a_neg;
                    cnt   <= CNT_W'(DATA_W - 1);
                    if (div_zero) begin
                        quo  <= '1;
                        rem  <= a_r;
                        skip <= 1'b1;
                    end else if (overflow) begin
                        quo  <= MIN_VAL;
                        rem  <= '0;
                        skip <= 1'b1;
                    end else begin
                        quo  <= a_abs;
                        rem  <= '0;
                        b_r  <= b_abs;
                        skip <= 1'b0;
                    end
                end
                CS_ITER: begin
                    if (!diff[DATA_W]) begin
                        rem <= diff[DATA_W-1:0];
                        quo <= {quo[DATA_W-2:0], 1'b1};
                    end else begin
                        rem <= shifted[DATA_W-1:0];
                        quo <= {quo[DATA_W-2:0], 1'b0};
                    end
                    cnt <= cnt - CNT_W'(1);
                end
                CS_FIX: begin
                    if (!skip) begin
                        if (neg_q) quo <= -quo;
                        if (neg_r) rem <= -rem;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy   = (state != CS_IDLE);
    assign done   = (state == CS_DONE);
    assign tag    = tag_r;
    assign result = op_r[OP_REM_BIT] ? rem : quo;

endmodule

// File: rtl/unit_div_rs.sv
// Divide functional unit: a small array of reservation stations that capture
// operands from the CDB, dispatch in station order to one shared iterative
// divider, and return results over the CDB with a request/grant handshake.
module unit_div_rs
    import tomasulo_pkg::*;
#(
    parameter logic [UNIT_ID_W-1:0] UNIT_ID = 5'b00100,
    parameter int                   NUM_RS  = 3,
    parameter int                   DATA_W  = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    issue,
    input  logic [1:0]              op_in,
    input  logic [TAG_W-1:0]        q1_in,
    input  logic [TAG_W-1:0]        q2_in,
    input  logic [DATA_W-1:0]       v1_in,
    input  logic [DATA_W-1:0]       v2_in,
    input  logic [DATA_W+TAG_W:0]   cdb,
    input  logic                    cdb_grant,
    output logic                    all_busy,
    output logic [TAG_W-1:0]        issue_tag,
    output logic                    cdb_request,
    output logic [DATA_W+TAG_W-1:0] cdb_out
);

    localparam int IDX_W     = (NUM_RS > 1) ? $clog2(NUM_RS) : 1;
    localparam int VALID_BIT = cdb_valid_bit(DATA_W);
    localparam int TAG_LSB   = cdb_tag_lsb(DATA_W);

    logic [NUM_RS-1:0] busy, disp, ready;
    logic [1:0]        st_op [NUM_RS];
    logic [TAG_W-1:0]  st_q1 [NUM_RS];
    logic [TAG_W-1:0]  st_q2 [NUM_RS];
    logic [DATA_W-1:0] st_v1 [NUM_RS];
    logic [DATA_W-1:0] st_v2 [NUM_RS];

    logic [IDX_W-1:0]  free_idx, sel_idx, cur_idx;
    logic              cdb_valid, start, core_busy, core_done;
    logic [TAG_W-1:0]  cdb_tag, core_tag;
    logic [DATA_W-1:0] cdb_val, core_result;

    assign cdb_valid = cdb[VALID_BIT];
    assign cdb_tag   = cdb[TAG_LSB +: TAG_W];
    assign cdb_val   = cdb[DATA_W-1:0];

    // Lowest free station for issue and lowest ready station for dispatch.
    always_comb begin
        free_idx = '0;
        sel_idx  = '0;
        ready    = '0;
        for (int i = NUM_RS - 1; i >= 0; i--) begin
            ready[i] = busy[i] && !disp[i] && (st_q1[i] == '0) && (st_q2[i] == '0);
            if (!busy[i])  free_idx = IDX_W'(i);
            if (ready[i])  sel_idx  = IDX_W'(i);
        end
    end

    assign all_busy  = &busy;
    assign issue_tag = all_busy ? '0 : {UNIT_ID, RS_IDX_W'(free_idx) + RS_IDX_W'(1)};
    assign start     = !core_busy && (|ready);

    // Station state: operand capture, issue with bypass, dispatch marking, release on grant.
    always_ff @(posedge clk) begin
        if (!rst) begin
            busy    <= '0;
            disp    <= '0;
            cur_idx <= '0;
            for (int i = 0; i < NUM_RS; i++) begin
                st_op[i] <= '0;
                st_q1[i] <= '0;
                st_q2[i] <= '0;
                st_v1[i] <= '0;
                st_v2[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_RS; i++) begin
                if (busy[i] && cdb_valid) begin
                    if (st_q1[i] != '0 && cdb_tag == st_q1[i]) begin
                        st_v1[i] <= cdb_val;
                        st_q1[i] <= '0;
                    end
                    if (st_q2[i] != '0 && cdb_tag == st_q2[i]) begin
                        st_v2[i] <= cdb_val;
                        st_q2[i] <= '0;
                    end
                end
            end
            if (issue && !all_busy) begin
                busy[free_idx]  <= 1'b1;
                disp[free_idx]  <= 1'b0;
                st_op[free_idx] <= op_in;
                if (q1_in != '0 && cdb_valid && cdb_tag == q1_in) begin
                    st_q1[free_idx] <= '0;
                    st_v1[free_idx] <= cdb_val;
                end else begin
                    st_q1[free_idx] <= q1_in;
                    st_v1[free_idx] <= v1_in;
                end
                if (q2_in != '0 && cdb_valid && cdb_tag == q2_in) begin
                    st_q2[free_idx] <= '0;
                    st_v2[free_idx] <= cdb_val;
                end else begin
                    st_q2[free_idx] <= q2_in;
                    st_v2[free_idx] <= v2_in;
                end
            end
            if (start) begin
                disp[sel_idx] <= 1'b1;
                cur_idx       <= sel_idx;
            end
            if (core_done && cdb_grant) begin
                busy[cur_idx] <= 1'b0;
                disp[cur_idx] <= 1'b0;
            end
        end
    end

    div_iter_core #(
        .DATA_W (DATA_W)
    ) u_core (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (st_op[sel_idx]),
        .dividend (st_v1[sel_idx]),
        .divisor  (st_v2[sel_idx]),
        .tag_in   ({UNIT_ID, RS_IDX_W'(sel_idx) + RS_IDX_W'(1)}),
        .ack      (cdb_grant),
        .busy     (core_busy),
        .done     (core_done),
        .tag      (core_tag),
        .result   (core_result)
    );

    assign cdb_request = core_done;
    assign cdb_out     = core_done ? {core_tag, core_result} : '0;

endmodule

// File: tb/tb_unit_div_rs.sv
// Self-checking bench for unit_div_rs: directed and random divide operations
// compared against plain-arithmetic expectations, plus capture, bypass,
// back-pressure, ordering and mid-operation reset scenarios.
module tb_unit_div_rs;

    localparam int DW  = 32;
    localparam int NRS = 3;
    localparam logic [4:0]  UID     = 5'b00100;
    localparam logic [31:0] MIN_VAL = 32'h80000000;
    localparam int NORMAL_LAT  = DW + 3;
    localparam int SPECIAL_LAT = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          issue = 1'b0;
    logic [1:0]    op_in = '0;
    logic [7:0]    q1_in = '0, q2_in = '0;
    logic [DW-1:0] v1_in = '0, v2_in = '0;
    logic [DW+8:0] cdb = '0;
    logic          cdb_grant = 1'b0;
    logic          all_busy;
    logic [7:0]    issue_tag;
    logic          cdb_request;
    logic [DW+7:0] cdb_out;

    int passes = 0;
    int fails  = 0;
    int total  = 0;

    unit_div_rs #(
        .UNIT_ID (UID),
        .NUM_RS  (NRS),
        .DATA_W  (DW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .issue       (issue),
        .op_in       (op_in),
        .q1_in       (q1_in),
        .q2_in       (q2_in),
        .v1_in       (v1_in),
        .v2_in       (v2_in),
        .cdb         (cdb),
        .cdb_grant   (cdb_grant),
        .all_busy    (all_busy),
        .issue_tag   (issue_tag),
        .cdb_request (cdb_request),
        .cdb_out     (cdb_out)
    );

    always #5 clk = ~clk;

    // Reference result straight from the arithmetic definition of each op.
    function automatic logic [31:0] refResult(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa, sb;
        sa = a;
        sb = b;
        case (op)
            2'b00: begin
                if (b == 0) return 32'hFFFFFFFF;
                if (a == MIN_VAL && b == 32'hFFFFFFFF) return MIN_VAL;
                return sa / sb;
            end
            2'b01: return (b == 0) ? 32'hFFFFFFFF : a / b;
            2'b10: begin
                if (b == 0) return a;
                if (a == MIN_VAL && b == 32'hFFFFFFFF) return 32'd0;
                return sa % sb;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int refLatency(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        if (b == 0) return SPECIAL_LAT;
        if (!op[0] && a == MIN_VAL && b == 32'hFFFFFFFF) return SPECIAL_LAT;
        return NORMAL_LAT;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] observed, input logic [63:0] expected);
        total++;
        assert (observed === expected) passes++;
        else begin
            fails++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", name, observed, expected);
        end
    endtask

    // Presents one issue (optionally with a same-cycle CDB broadcast) for one edge.
    task automatic applyStimulus(input logic [1:0] op, input logic [7:0] q1, input logic [7:0] q2,
                                 input logic [31:0] v1, input logic [31:0] v2, input logic [DW+8:0] bus);
        issue = 1'b1;
        op_in = op;
        q1_in = q1;
        q2_in = q2;
        v1_in = v1;
        v2_in = v2;
        cdb   = bus;
        @(negedge clk);
        issue = 1'b0;
        q1_in = '0;
        q2_in = '0;
        v1_in = '0;
        v2_in = '0;
        cdb   = '0;
    endtask

    task automatic waitRequest(output int cycles);
        cycles = 0;
        while (cdb_request !== 1'b1 && cycles < 200) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic grantResult();
        cdb_grant = 1'b1;
        @(negedge clk);
        cdb_grant = 1'b0;
    endtask

    task automatic runOp(input string name, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        int lat;
        applyStimulus(op, 8'd0, 8'd0, a, b, '0);
        waitRequest(lat);
        checkOutput({name, " latency"}, 64'(lat), 64'(refLatency(op, a, b)));
        checkOutput({name, " result"}, 64'(cdb_out), 64'({UID, 3'd1, refResult(op, a, b)}));
        grantResult();
        checkOutput({name, " released"}, 64'(cdb_request), 64'd0);
    endtask

    initial begin
        int lat;
        logic [1:0]  bop [4];
        logic [31:0] ba [4];
        logic [31:0] bb [4];
        logic [39:0] held;
        logic [1:0]  rop;
        logic [31:0] ra, rb;

        // Reset state.
        repeat (2) @(negedge clk);
        checkOutput("reset request", 64'(cdb_request), 64'd0);
        checkOutput("reset out", 64'(cdb_out), 64'd0);
        checkOutput("reset all_busy", 64'(all_busy), 64'd0);
        checkOutput("reset issue_tag", 64'(issue_tag), 64'({UID, 3'd1}));
        rst = 1'b1;
        @(negedge clk);

        // Directed operations including the divide-by-zero and overflow corners.
        runOp("divu 100/7", 2'b01, 32'd100, 32'd7);
        checkOutput("all_busy after grant", 64'(all_busy), 64'd0);
        runOp("rem -7/2", 2'b10, 32'hFFFFFFF9, 32'd2);
        runOp("div -7/2", 2'b00, 32'hFFFFFFF9, 32'd2);
        runOp("div 5/0", 2'b00, 32'd5, 32'd0);
        runOp("remu 5/0", 2'b11, 32'd5, 32'd0);
        runOp("div min/-1", 2'b00, MIN_VAL, 32'hFFFFFFFF);
        runOp("rem min/-1", 2'b10, MIN_VAL, 32'hFFFFFFFF);
        runOp("divu min/-1", 2'b01, MIN_VAL, 32'hFFFFFFFF);

        // Random operations.
        for (int k = 0; k < 12; k++) begin
            rop = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 4))
                0:       ra = MIN_VAL;
                1:       ra = -32'($urandom_range(1, 500));
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0:       rb = 32'd0;
                1:       rb = 32'hFFFFFFFF;
                2:       rb = 32'($urandom_range(1, 20));
                3:       rb = -32'($urandom_range(1, 20));
                default: rb = $urandom;
            endcase
            runOp($sformatf("rand%0d", k), rop, ra, rb);
        end

        // Operand captured from a later CDB broadcast.
        applyStimulus(2'b01, 8'b00001_010, 8'd0, 32'd999, 32'd4, '0);
        repeat (2) @(negedge clk);
        checkOutput("capture pending request", 64'(cdb_request), 64'd0);
        checkOutput("capture issue_tag", 64'(issue_tag), 64'({UID, 3'd2}));
        cdb = {1'b1, 8'b00001_010, 32'd40};
        @(negedge clk);
        cdb = '0;
        waitRequest(lat);
        checkOutput("capture latency", 64'(lat), 64'(NORMAL_LAT));
        checkOutput("capture result", 64'(cdb_out), 64'({UID, 3'd1, 32'd10}));
        grantResult();

        // Operand bypassed from a broadcast in the issue cycle.
        applyStimulus(2'b01, 8'b00001_010, 8'd0, 32'd999, 32'd4, {1'b1, 8'b00001_010, 32'd40});
        waitRequest(lat);
        checkOutput("bypass latency", 64'(lat), 64'(NORMAL_LAT));
        checkOutput("bypass result", 64'(cdb_out), 64'({UID, 3'd1, 32'd10}));
        grantResult();

        // Four back-to-back issues into three stations, results held then drained in order.
        for (int k = 0; k < 4; k++) begin
            bop[k] = 2'($urandom_range(0, 3));
            ba[k]  = $urandom;
            bb[k]  = 32'($urandom_range(1, 1000));
        end
        for (int k = 0; k < 4; k++) begin
            if (k == 3) begin
                checkOutput("full all_busy", 64'(all_busy), 64'd1);
                checkOutput("full issue_tag", 64'(issue_tag), 64'd0);
            end
            applyStimulus(bop[k], 8'd0, 8'd0, ba[k], bb[k], '0);
        end
        waitRequest(lat);
        held = {UID, 3'd1, refResult(bop[0], ba[0], bb[0])};
        checkOutput("order st1 result", 64'(cdb_out), 64'(held));
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checkOutput($sformatf("hold%0d out", c), 64'(cdb_out), 64'(held));
            checkOutput($sformatf("hold%0d request", c), 64'(cdb_request), 64'd1);
        end
        grantResult();
        for (int k = 1; k < 3; k++) begin
            waitRequest(lat);
            checkOutput($sformatf("order st%0d latency", k + 1), 64'(lat), 64'(refLatency(bop[k], ba[k], bb[k])));
            checkOutput($sformatf("order st%0d result", k + 1), 64'(cdb_out),
                        64'({UID, 3'(k + 1), refResult(bop[k], ba[k], bb[k])}));
            grantResult();
        end
        repeat (40) @(negedge clk);
        checkOutput("fourth ignored request", 64'(cdb_request), 64'd0);
        checkOutput("drained all_busy", 64'(all_busy), 64'd0);

        // Reset in the middle of an iteration, then a fresh operation.
        applyStimulus(2'b01, 8'd0, 8'd0, 32'd1000, 32'd3, '0);
        repeat (10) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("midreset request", 64'(cdb_request), 64'd0);
        checkOutput("midreset all_busy", 64'(all_busy), 64'd0);
        checkOutput("midreset issue_tag", 64'(issue_tag), 64'({UID, 3'd1}));
        rst = 1'b1;
        @(negedge clk);
        runOp("after reset", 2'b00, 32'hFFFFFC18, 32'd7);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
